// File: rtl/data_mem_mp_pkg.sv
// Shared types and constants for the multi-port data memory.
package data_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

endpackage

// File: rtl/data_mem_mp_if.sv
// Request/ack bus between requesters (master) and the memory (slave).
// Handshake: a requester raises req with stable addr/data and holds it until
// ack; ack is a one-cycle pulse in the cycle the access is performed. Read
// data follows on rd_valid, a one-cycle pulse RD_LATENCY cycles after rd_ack.
interface data_mem_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_RD     = 2
);
  logic                         wr_req;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [DATA_WIDTH/8-1:0]      wr_be;
  logic                         wr_ack;
  logic [NUM_RD-1:0]            rd_req;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_ack;
  logic [NUM_RD-1:0]            rd_valid;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic                         init_done;

  modport master (
    output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
    input  wr_ack, rd_ack, rd_valid, rd_data, init_done
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
    output wr_ack, rd_ack, rd_valid, rd_data, init_done
  );
endinterface

// File: rtl/data_mem_mp_rr_arbiter.sv
// Round-robin arbiter: searches from the index after the last grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found              = 1'b1;
        grant[PW'(idx)]    = 1'b1;
        grant_idx          = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/data_mem_mp.sv
// Byte-enabled memory with one write port and NUM_RD read channels sharing a
// single access slot per cycle, cleared by a zero-fill sweep after reset.
module data_mem_mp
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int RD_LATENCY = RD_LAT_1
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_mp_if.slave  bus,
  output state_t        dbg_state
);
  localparam int NREQ  = NUM_RD + 1;
  localparam int BYTES = DATA_WIDTH / 8;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  run;
  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       grant;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word [NUM_RD];
  logic [NUM_RD-1:0]     v_pipe [RD_LATENCY];
  logic [DATA_WIDTH-1:0] d_pipe [RD_LATENCY][NUM_RD];

  assign clr_last  = (clr_cnt == ADDR_WIDTH'(MEM_DEPTH - 1));
  assign run       = (state == ST_RUN);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (clr_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Requests are masked during the clear sweep so no ack can escape INIT.
  assign arb_req = run ? {bus.rd_req, bus.wr_req} : '0;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (|grant),
    .grant   (grant)
  );

  assign bus.wr_ack    = grant[0];
  assign bus.rd_ack    = grant[NREQ-1:1];
  assign bus.init_done = run;

  // Storage has no reset; the INIT sweep is the only clear.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else if (bus.wr_ack && (int'(bus.wr_addr) < MEM_DEPTH)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.wr_be[b]) mem[bus.wr_addr][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a          = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word[k] = (int'(a) < MEM_DEPTH) ? mem[a] : '0;
    end
  end

  // Data stages load only on a valid, so the last stage holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        v_pipe[s] <= '0;
        for (int k = 0; k < NUM_RD; k++) d_pipe[s][k] <= '0;
      end
    end else begin
      v_pipe[0] <= bus.rd_ack;
      for (int k = 0; k < NUM_RD; k++) begin
        if (bus.rd_ack[k]) d_pipe[0][k] <= rd_word[k];
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        for (int k = 0; k < NUM_RD; k++) begin
          if (v_pipe[s-1][k]) d_pipe[s][k] <= d_pipe[s-1][k];
        end
      end
    end
  end

  assign bus.rd_valid = v_pipe[RD_LATENCY-1];

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = d_pipe[RD_LATENCY-1][k];
    end
  end
endmodule

// File: tb/tb_data_mem_mp.sv
// Bench for data_mem_mp: directed vectors, a per-cycle reference model and
// literal expectations; a second instance exercises RD_LATENCY=2 and reset.
module tb_data_mem_mp;
  import data_mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int NRD   = 2;

  logic   clk    = 1'b0;
  logic   reset  = 1'b1;
  logic   reset2 = 1'b1;
  state_t dbg_state, dbg_state2;
  int     n_checks = 0;
  int     n_errors = 0;

  data_mem_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD)) bus ();
  data_mem_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD)) bus2 ();

  data_mem_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
                .NUM_RD(NRD), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state));

  data_mem_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
                .NUM_RD(NRD), .RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2), .dbg_state(dbg_state2));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  initial begin : watchdog
    #300000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  // ---------------- reference model + compare ----------------
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] last_d [NRD];
  int          last_g;
  int          n_init;

  initial begin : compare
    logic [31:0]   d;
    logic [31:0]   act;
    logic          exp_v;
    logic          rq;
    logic [AW-1:0] a;
    int            g;
    int            idx;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
        chk("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data0", bus.rd_data[31:0], 32'd0);
        chk("rst_rd_data1", bus.rd_data[63:32], 32'd0);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        n_init = 0;
        last_g = NRD;
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < NRD; k++) last_d[k] = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else begin
        for (int k = 0; k < NRD; k++) begin
          act = bus.rd_data[k*DW +: DW];
          d   = '0;
          if (k == 0) begin
            exp_v = (exp_q0.size() != 0);
            if (exp_v) d = exp_q0.pop_front();
          end else begin
            exp_v = (exp_q1.size() != 0);
            if (exp_v) d = exp_q1.pop_front();
          end
          chk($sformatf("rd_valid%0d", k), 32'(bus.rd_valid[k]), 32'(exp_v));
          if (exp_v) begin
            chk($sformatf("rd_data%0d", k), act, d);
            last_d[k] = d;
          end else begin
            chk($sformatf("rd_hold%0d", k), act, last_d[k]);
          end
        end
        chk("init_done", 32'(bus.init_done), 32'(n_init >= DEPTH));
        g = -1;
        if (n_init >= DEPTH) begin
          for (int i = 1; i <= NRD + 1; i++) begin
            idx = (last_g + i) % (NRD + 1);
            rq  = (idx == 0) ? bus.wr_req : bus.rd_req[idx-1];
            if (g < 0 && rq) g = idx;
          end
        end
        chk("wr_ack", 32'(bus.wr_ack), 32'(g == 0));
        chk("rd_ack", 32'(bus.rd_ack), (g > 0) ? (32'd1 << (g - 1)) : 32'd0);
        if (g == 0) begin
          a = bus.wr_addr;
          if (int'(a) < DEPTH) begin
            for (int b = 0; b < DW / 8; b++) begin
              if (bus.wr_be[b]) model_mem[a][b*8 +: 8] = bus.wr_data[b*8 +: 8];
            end
          end
          last_g = 0;
        end else if (g > 0) begin
          a = bus.rd_addr[(g-1)*AW +: AW];
          d = (int'(a) < DEPTH) ? model_mem[a] : 32'd0;
          if (g == 1) exp_q0.push_back(d);
          else        exp_q1.push_back(d);
          last_g = g;
        end
        if (n_init < DEPTH) n_init++;
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] dat, input logic [3:0] be);
    int t;
    t = 0;
    bus.wr_addr = a;
    bus.wr_data = dat;
    bus.wr_be   = be;
    bus.wr_req  = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.wr_ack && t < 50);
    if (!bus.wr_ack) chk("wr_timeout", 32'(bus.wr_ack), 32'd1);
    @(posedge clk);
    #1 bus.wr_req = 1'b0;
  endtask

  task automatic do_read(input int ch, input logic [AW-1:0] a, output logic [31:0] dat);
    int t;
    t   = 0;
    dat = '0;
    bus.rd_addr[ch*AW +: AW] = a;
    bus.rd_req[ch] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rd_ack[ch] && t < 50);
    if (!bus.rd_ack[ch]) chk("rd_ack_timeout", 32'(bus.rd_ack[ch]), 32'd1);
    @(posedge clk);
    #1 bus.rd_req[ch] = 1'b0;
    @(negedge clk);
    chk("rd_latency1", 32'(bus.rd_valid[ch]), 32'd1);
    dat = bus.rd_data[ch*DW +: DW];
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] sweep_exp [DEPTH];

  initial begin : stim
    logic [31:0] rd;
    int          cnt;
    int          gseq [9];
    int          gexp [9];

    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_req = '0; bus.rd_addr = '0;
    bus2.wr_req = 0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_be = '0;
    bus2.rd_req = '0; bus2.rd_addr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(ST_INIT));
    @(posedge clk);
    #1 reset = 1'b0;

    // Clear sweep length: 12 cycles in INIT, then RUN.
    cnt = 0;
    @(negedge clk);
    while (!bus.init_done && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("init_cycles", 32'(cnt), 32'd12);
    chk("run_state", 32'(dbg_state), 32'(ST_RUN));
    @(posedge clk);
    #1;
    do_read(0, 4'd11, rd);
    chk("init_rd11", rd, 32'h0000_0000);

    // Byte-enable merge, then an all-zero mask write.
    do_write(4'd3, 32'hAABB_CCDD, 4'hF);
    do_write(4'd3, 32'h1122_3344, 4'h5);
    do_read(1, 4'd3, rd);
    chk("be_merge", rd, 32'hAA22_CC44);
    do_write(4'd3, 32'hFFFF_FFFF, 4'h0);
    do_read(1, 4'd3, rd);
    chk("be_zero", rd, 32'hAA22_CC44);

    // Write and channel-0 read of the same address raised together.
    bus.wr_addr = 4'd7; bus.wr_data = 32'h5A5A_5A5A; bus.wr_be = 4'hF;
    bus.rd_addr[0 +: AW] = 4'd7;
    bus.wr_req = 1'b1; bus.rd_req[0] = 1'b1;
    @(negedge clk);
    chk("raw_wr_first", 32'(bus.wr_ack), 32'd1);
    chk("raw_rd_wait", 32'(bus.rd_ack), 32'd0);
    @(posedge clk);
    #1 bus.wr_req = 1'b0;
    @(negedge clk);
    chk("raw_rd_ack", 32'(bus.rd_ack), 32'd1);
    @(posedge clk);
    #1 bus.rd_req[0] = 1'b0;
    @(negedge clk);
    chk("raw_valid", 32'(bus.rd_valid), 32'd1);
    chk("raw_data", bus.rd_data[31:0], 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    do_read(1, 4'd7, rd);
    chk("raw_ch1", rd, 32'h5A5A_5A5A);

    // Full contention for 9 cycles: W, R0, R1 repeating.
    bus.wr_addr = 4'd5; bus.wr_data = 32'h0102_0304; bus.wr_be = 4'hF;
    bus.rd_addr = {4'd7, 4'd3};
    bus.wr_req = 1'b1; bus.rd_req = 2'b11;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      gseq[i] = bus.wr_ack ? 0 : bus.rd_ack[0] ? 1 : bus.rd_ack[1] ? 2 : 3;
      gexp[i] = i % 3;
      @(posedge clk);
      #1;
    end
    bus.wr_req = 1'b0; bus.rd_req = 2'b00;
    for (int i = 0; i < 9; i++) chk($sformatf("contend_g%0d", i), 32'(gseq[i]), 32'(gexp[i]));
    @(negedge clk);
    @(posedge clk);
    #1;

    // Out-of-range write and read.
    do_write(4'd13, 32'hDEAD_BEEF, 4'hF);
    do_read(0, 4'd13, rd);
    chk("oor_read", rd, 32'h0000_0000);
    for (int i = 0; i < DEPTH; i++) sweep_exp[i] = 32'h0;
    sweep_exp[3] = 32'hAA22_CC44;
    sweep_exp[5] = 32'h0102_0304;
    sweep_exp[7] = 32'h5A5A_5A5A;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i % 2, AW'(i), rd);
      chk($sformatf("sweep_a%0d", i), rd, sweep_exp[i]);
    end

    // Second instance: RD_LATENCY=2 and reset with a read in flight.
    #1 reset2 = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (!bus2.init_done && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("l2_init_cycles", 32'(cnt), 32'd12);
    @(posedge clk);
    #1;
    bus2.wr_addr = 4'd2; bus2.wr_data = 32'h1234_5678; bus2.wr_be = 4'hF; bus2.wr_req = 1'b1;
    @(negedge clk);
    chk("l2_wr_ack", 32'(bus2.wr_ack), 32'd1);
    @(posedge clk);
    #1 bus2.wr_req = 1'b0;
    bus2.rd_addr = {4'd2, 4'd0}; bus2.rd_req = 2'b10;
    @(negedge clk);
    chk("l2_rd_ack", 32'(bus2.rd_ack), 32'd2);
    @(posedge clk);
    #1 bus2.rd_req = 2'b00;
    @(negedge clk);
    chk("l2_valid_early", 32'(bus2.rd_valid), 32'd0);
    @(negedge clk);
    chk("l2_valid", 32'(bus2.rd_valid), 32'd2);
    chk("l2_data", bus2.rd_data[63:32], 32'h1234_5678);
    @(posedge clk);
    #1 bus2.rd_req = 2'b10;
    @(negedge clk);
    chk("l2_rd_ack2", 32'(bus2.rd_ack), 32'd2);
    @(posedge clk);
    #1 bus2.rd_req = 2'b00;
    reset2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("l2_rst_valid%0d", i), 32'(bus2.rd_valid), 32'd0);
      chk($sformatf("l2_rst_data%0d", i), bus2.rd_data[63:32], 32'd0);
      chk($sformatf("l2_rst_init%0d", i), 32'(bus2.init_done), 32'd0);
    end
    chk("l2_rst_state", 32'(dbg_state2), 32'(ST_INIT));
    @(posedge clk);
    #1 reset2 = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (!bus2.init_done && cnt < 100) begin
      chk("l2_no_valid", 32'(bus2.rd_valid), 32'd0);
      cnt++;
      @(negedge clk);
    end
    chk("l2_reinit_cycles", 32'(cnt), 32'd12);

    repeat (2) @(posedge clk);
    finish_sim();
  end
endmodule

// File: doc/data_mem_mp.md
DATA_MEM_MP -- requirements
Module: data_mem_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, address width.
REQ-003 Parameter MEM_DEPTH, default 1 << ADDR_WIDTH, number of words; SHALL be 2 to 2^ADDR_WIDTH.
REQ-004 Parameter NUM_RD, default 2, number of read channels, 1 to 8.
REQ-005 Parameter RD_LATENCY, default 1, cycles from rd_ack to rd_valid; legal values 1 and 2.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 wr_req  input  1  write request, held until wr_ack.
REQ-009 wr_addr  input  ADDR_WIDTH  write address, stable while wr_req high.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 wr_be  input  DATA_WIDTH/8  byte enables; bit n covers byte n.
REQ-012 wr_ack  output  1  one-cycle pulse; the write is performed in this cycle.
REQ-013 rd_req  input  NUM_RD  per-channel read request, held until rd_ack.
REQ-014 rd_addr  input  NUM_RD*ADDR_WIDTH  packed per-channel addresses; channel k uses slice k.
REQ-015 rd_ack  output  NUM_RD  per-channel one-cycle grant pulse.
REQ-016 rd_valid  output  NUM_RD  per-channel one-cycle pulse; rd_data slice is valid in that cycle.
REQ-017 rd_data  output  NUM_RD*DATA_WIDTH  packed per-channel read data.
REQ-018 init_done  output  1  high once the memory clear sweep has completed.

Function
REQ-019 The block SHALL have states INIT and RUN. INIT writes zero to address clr_cnt each cycle, clr_cnt counting 0 to MEM_DEPTH-1. The block SHALL enter RUN on the cycle after clr_cnt = MEM_DEPTH-1.
REQ-020 In INIT, no ack SHALL be asserted and init_done SHALL be 0. In RUN, init_done SHALL be 1.
REQ-021 In RUN, one access per cycle. NUM_RD+1 requesters: index 0 = write, index k+1 = read channel k. They SHALL be served round-robin, starting from the index after the last granted one. After reset the pointer starts at index 0.
REQ-022 Exactly one of wr_ack and rd_ack bits, or none, SHALL be high in any cycle. An ack SHALL be asserted only while the matching req is high.
REQ-023 A write SHALL update only the bytes whose wr_be bit is 1. wr_be = 0 SHALL still ack with no change.
REQ-024 A read SHALL sample memory at the ack cycle. rd_valid[k] SHALL pulse exactly RD_LATENCY cycles after rd_ack[k].
REQ-025 The rd_data slice for a channel SHALL hold its value until that channel's next rd_valid.
REQ-026 Accesses SHALL take effect in grant order. A read granted after a write to the same address SHALL return the new data.
REQ-027 Out-of-range addresses (>= MEM_DEPTH) SHALL be acked. Writes to them SHALL have no effect, and reads from them SHALL return all zeros.
REQ-028 A requester that drops req before its ack SHALL be skipped without penalty. A requester that keeps req high after its ack SHALL be treated as a new request.
REQ-029 With all requesters continuously active, each SHALL be granted exactly once in every NUM_RD+1 consecutive cycles.

Reset
REQ-030 While reset is high, outputs SHALL be: wr_ack = 0, rd_ack = 0, rd_valid = 0, rd_data = 0, init_done = 0. The state SHALL be INIT, clr_cnt = 0 and the arbiter pointer = 0.
REQ-031 Reset during RUN SHALL discard in-flight reads, with no rd_valid after reset. After reset deasserts, the block SHALL redo the full INIT sweep.

Structure
REQ-032 Package data_mem_pkg SHALL hold the state type (INIT, RUN) and the legal RD_LATENCY constants.
REQ-033 Round-robin arbitration SHALL be a sub-module rr_arbiter, parametrised by requester count, with ports req, grant (one-hot) and advance.
REQ-034 The memory array SHALL have no reset; it is cleared only by INIT.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, MEM_DEPTH=12, NUM_RD=2, RD_LATENCY=1 unless noted)
REQ-035 Init check: release reset -> init_done rises after 12 cycles. A read of addr 11 then returns 0x00000000.
REQ-036 Byte-enable merge: write 0xAABBCCDD to addr 3 with wr_be=0xF, then write 0x11223344 with wr_be=0x5 -> read of addr 3 returns 0xAA22CC44.
REQ-037 Full contention: all three requesters held high for 9 cycles -> grant order W, R0, R1 repeated three times. rd_valid[k] follows each rd_ack[k] by 1 cycle.
REQ-038 Out-of-range access: write 0xDEADBEEF to addr 13, then read addr 13 -> both acked, read returns 0. Addresses 0 to 11 unchanged.
REQ-039 Reset mid-operation: assert reset one cycle after rd_ack[1] with RD_LATENCY=2 -> no rd_valid[1]; the INIT sweep restarts and runs 12 cycles.
REQ-040 RAW ordering: write 0x5A5A5A5A to addr 7 and channel 0 read of addr 7 requested together, pointer at 0 -> write granted first, read returns 0x5A5A5A5A.
